any1_periph_bridge: RTL and testbench
=====================================

ANY1_PERIPH_BRIDGE -- requirements
Module: any1_periph_bridge

Interface
REQ-001 SHALL have parameter NSLV, default 4, number of 32-bit peripheral channels (1..8).
REQ-002 SHALL have parameter TMO, default 255, timeout limit in clock cycles (1..65535).
REQ-003 SHALL have one clock; reset is synchronous and active-high: ports clk_i and rst_i.
REQ-004 clk_i  in  1  system clock; all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 m_cyc_i, m_stb_i, m_we_i  in  1 each  CPU-side bus cycle, strobe, write.
REQ-007 m_sel_i  in  16  byte selects; m_adr_i  in  32  byte address; m_dat_i  in  128  write data.
REQ-008 m_ack_o, m_err_o  out  1 each  CPU-side completion / error pulse.
REQ-009 m_dat_o  out  128  read data, 32-bit slave word replicated to all four lanes.
REQ-010 sbase_i  in  NSLV*24  per-channel page base; channel n matches when m_adr_i[31:8]==sbase_i[n*24+:24].
REQ-011 s_cs_o  out  NSLV  one-hot channel select.
REQ-012 s_cyc_o, s_stb_o, s_we_o  out  1 each  peripheral-side cycle, strobe, write.
REQ-013 s_sel_o  out  4; s_adr_o  out  32; s_dat_o  out  32  peripheral-side selects, address, write data.
REQ-014 s_ack_i  in  NSLV  per-channel ack; s_dat_i  in  NSLV*32  per-channel read data.

Function
REQ-015 SHALL implement states IDLE, REQ, DONE, HOLD.
REQ-016 IDLE: on m_cyc_i&m_stb_i, sample request; legal+matched -> REQ; illegal or unmatched -> DONE with error.
REQ-017 Lane decode: exactly one nonzero nybble k of m_sel_i -> s_adr_o={m_adr_i[31:4],k[1:0],2'b00}, s_sel_o=nybble k, s_dat_o=m_dat_i[32k+:32].
REQ-018 More than one nonzero nybble, or m_sel_i==0, SHALL be illegal.
REQ-019 Multiple sbase matches: lowest channel index SHALL win.
REQ-020 REQ: s_cyc_o/s_stb_o/s_cs_o asserted first cycle after sampling (1-cycle registered latency).
REQ-021 REQ: s_ack_i of selected channel -> capture {4{s_dat_i[n]}} into m_dat_o, -> DONE; acks of unselected channels ignored.
REQ-022 DONE: m_ack_o or m_err_o high exactly one cycle; s_cyc_o/s_stb_o/s_cs_o low; -> HOLD.
REQ-023 HOLD: stay until m_stb_i==0, then IDLE; no new request accepted before.
REQ-024 m_cyc_i low in REQ SHALL abort: drop s_* next cycle, no ack/err, -> IDLE.
REQ-025 m_ack_o and m_err_o SHALL never be high together.
REQ-026 m_dat_o SHALL hold last captured value outside DONE; unchanged on writes and errors.

Reset
REQ-027 rst_i SHALL force IDLE, clear timeout counter, all outputs 0 by next edge, including mid-transaction.
REQ-028 Slave ack arriving the cycle rst_i is high SHALL be discarded.

Configuration
REQ-029 Macro ANY1_BRIDGE_TIMEOUT_EN defined: counter clears on REQ entry, increments each REQ cycle; reaching TMO without ack -> DONE with m_err_o.
REQ-030 ANY1_BRIDGE_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for ack; TMO unused.
REQ-031 Ack in same cycle counter reaches TMO SHALL complete as ack, not error.

Verification
REQ-032 NSLV=4, sbase1=FFDC11; read adr FFDC1108, sel 00F0, ch1 acks 2 cycles later with 12345678 -> s_adr_o FFDC1104, m_ack_o 1 cycle, m_dat_o={4{12345678}}.
REQ-033 Write sel F000, m_dat_i[127:96]=CAFEBABE to ch0 -> s_dat_o CAFEBABE, s_sel_o F, s_adr_o[3:2]=11, s_we_o 1.
REQ-034 sel 00FF or adr matching no base -> m_err_o 1 cycle, s_cyc_o never asserted.
REQ-035 TIMEOUT_EN, TMO=8, silent slave -> m_err_o on cycle 8 of REQ; macro undefined -> still in REQ after 1000 cycles.
REQ-036 rst_i pulse during REQ, ack next cycle -> all outputs 0, no m_ack_o; m_stb_i held in HOLD -> no second transaction until low.

Source files
------------

// File: rtl/any1_periph_bridge.sv
// Bridges a 128-bit CPU-side bus cycle onto one of NSLV 32-bit peripheral channels selected by page base.
// Optional REQ timeout is compiled in with ANY1_BRIDGE_TIMEOUT_EN; otherwise REQ waits for ack forever.
module any1_periph_bridge #(
    parameter int NSLV = 4,
    parameter int TMO  = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               m_cyc_i,
    input  logic               m_stb_i,
    input  logic               m_we_i,
    input  logic [15:0]        m_sel_i,
    input  logic [31:0]        m_adr_i,
    input  logic [127:0]       m_dat_i,
    output logic               m_ack_o,
    output logic               m_err_o,
    output logic [127:0]       m_dat_o,
    input  logic [NSLV*24-1:0] sbase_i,
    output logic [NSLV-1:0]    s_cs_o,
    output logic               s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [NSLV*32-1:0] s_dat_i,
    output logic [1:0]         dbg_state
);

    // Handshake: a master request is taken when m_cyc_i & m_stb_i are high in IDLE; it ends with a
    // single-cycle m_ack_o or m_err_o, after which the master must drop m_stb_i before the next one.

    if (NSLV < 1 || NSLV > 8 || TMO < 1 || TMO > 65535) begin : g_param_check
        $error("any1_periph_bridge: NSLV or TMO out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state, state_n;

    logic [NSLV-1:0] s_cs_n;
    logic            s_cyc_n;
    logic            s_we_n;
    logic [3:0]      s_sel_n;
    logic [31:0]     s_adr_n;
    logic [31:0]     s_dat_n;
    logic            m_ack_n;
    logic            m_err_n;
    logic [127:0]    m_dat_n;

    logic [3:0]      lane_nz;
    logic [1:0]      lane;
    logic            lane_legal;
    logic [NSLV-1:0] hit;
    logic [31:0]     rdat;
    logic            sel_ack;

    // The byte address low nybble is replaced by the decoded lane, so those bits are not needed.
    logic unused_adr_bits;
    assign unused_adr_bits = &{1'b0, m_adr_i[3:0]};

`ifdef ANY1_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_cnt, tmo_cnt_n;
    logic        tmo_hit;
    assign tmo_hit = ({1'b0, tmo_cnt} + 17'd1) == 17'(TMO);
`endif

    assign dbg_state = state;

    always_comb begin
        lane_nz = 4'd0;
        lane    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            lane_nz[k] = |m_sel_i[4*k +: 4];
            if (lane_nz[k]) lane = 2'(k);
        end
        lane_legal = (lane_nz != 4'd0) && ((lane_nz & (lane_nz - 4'd1)) == 4'd0);
    end

    // Walk from the top channel down so the lowest matching index is the one left standing.
    always_comb begin
        hit = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (m_adr_i[31:8] == sbase_i[i*24 +: 24]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rdat = 32'd0;
        for (int i = 0; i < NSLV; i++) begin
            rdat = rdat | (s_dat_i[i*32 +: 32] & {32{s_cs_o[i]}});
        end
        sel_ack = |(s_ack_i & s_cs_o);
    end

    always_comb begin
        state_n = state;
        s_cs_n  = s_cs_o;
        s_cyc_n = s_cyc_o;
        s_we_n  = s_we_o;
        s_sel_n = s_sel_o;
        s_adr_n = s_adr_o;
        s_dat_n = s_dat_o;
        m_ack_n = 1'b0;
        m_err_n = 1'b0;
        m_dat_n = m_dat_o;
`ifdef ANY1_BRIDGE_TIMEOUT_EN
        tmo_cnt_n = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (lane_legal && (hit != '0)) begin
                        state_n = REQ;
                        s_cs_n  = hit;
                        s_cyc_n = 1'b1;
                        s_we_n  = m_we_i;
                        s_sel_n = m_sel_i[{lane, 2'b00} +: 4];
                        s_adr_n = {m_adr_i[31:4], lane, 2'b00};
                        s_dat_n = m_dat_i[{lane, 5'b00000} +: 32];
`ifdef ANY1_BRIDGE_TIMEOUT_EN
                        tmo_cnt_n = 16'd0;
`endif
                    end else begin
                        state_n = DONE;
                        m_err_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!m_cyc_i || sel_ack
`ifdef ANY1_BRIDGE_TIMEOUT_EN
                    || tmo_hit
`endif
                   ) begin
                    s_cs_n  = '0;
                    s_cyc_n = 1'b0;
                    s_we_n  = 1'b0;
                    s_sel_n = 4'd0;
                    s_adr_n = 32'd0;
                    s_dat_n = 32'd0;
                end
                // Abort beats ack; ack in the limit cycle beats timeout.
                if (!m_cyc_i) begin
                    state_n = IDLE;
                end else if (sel_ack) begin
                    state_n = DONE;
                    m_ack_n = 1'b1;
                    if (!s_we_o) m_dat_n = {4{rdat}};
                end
`ifdef ANY1_BRIDGE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_n = DONE;
                    m_err_n = 1'b1;
                end else begin
                    tmo_cnt_n = tmo_cnt + 16'd1;
                end
`endif
            end
            DONE: begin
                state_n = HOLD;
            end
            HOLD: begin
                if (!m_stb_i) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            s_cs_o  <= '0;
            s_cyc_o <= 1'b0;
            s_stb_o <= 1'b0;
            s_we_o  <= 1'b0;
            s_sel_o <= 4'd0;
            s_adr_o <= 32'd0;
            s_dat_o <= 32'd0;
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= 128'd0;
`ifdef ANY1_BRIDGE_TIMEOUT_EN
            tmo_cnt <= 16'd0;
`endif
        end else begin
            state   <= state_n;
            s_cs_o  <= s_cs_n;
            s_cyc_o <= s_cyc_n;
            s_stb_o <= s_cyc_n;
            s_we_o  <= s_we_n;
            s_sel_o <= s_sel_n;
            s_adr_o <= s_adr_n;
            s_dat_o <= s_dat_n;
            m_ack_o <= m_ack_n;
            m_err_o <= m_err_n;
            m_dat_o <= m_dat_n;
`ifdef ANY1_BRIDGE_TIMEOUT_EN
            tmo_cnt <= tmo_cnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_any1_periph_bridge.sv
// Directed bench for any1_periph_bridge: lane decode, channel match, ack/err, abort, reset, timeout.
module tb_any1_periph_bridge;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         m_cyc, m_stb, m_we;
    logic [15:0]  m_sel;
    logic [31:0]  m_adr;
    logic [127:0] m_dat_in;
    logic         m_ack, m_err;
    logic [127:0] m_dat_out;
    logic [95:0]  sbase;
    logic [3:0]   s_cs;
    logic         s_cyc, s_stb, s_we;
    logic [3:0]   s_sel;
    logic [31:0]  s_adr, s_dat_out;
    logic [3:0]   s_ack;
    logic [127:0] s_dat_in;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    any1_periph_bridge #(.NSLV(4), .TMO(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_sel_i(m_sel), .m_adr_i(m_adr), .m_dat_i(m_dat_in),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_dat_o(m_dat_out),
        .sbase_i(sbase), .s_cs_o(s_cs),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_adr_o(s_adr), .s_dat_o(s_dat_out),
        .s_ack_i(s_ack), .s_dat_i(s_dat_in),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic start(input logic we, input logic [15:0] sel, input logic [31:0] adr,
                         input logic [127:0] dat);
        m_cyc = 1'b1;
        m_stb = 1'b1;
        m_we = we;
        m_sel = sel;
        m_adr = adr;
        m_dat_in = dat;
    endtask

    task automatic finish_txn();
        s_ack = 4'd0;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        tick();
        tick();
        check("back_to_idle", 128'(dbg_state), 128'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_sel = 16'd0; m_adr = 32'd0; m_dat_in = 128'd0;
        s_ack = 4'd0; s_dat_in = 128'd0;
        // ch3 duplicates ch1's page to exercise lowest-index priority
        sbase = {24'hFFDC11, 24'hABCD00, 24'hFFDC11, 24'h123456};
        tick();
        tick();
        check("rst_outs", {m_ack, m_err, s_cyc, s_stb, s_we, s_cs, s_sel}, 128'd0);
        check("rst_mdat", m_dat_out, 128'd0);
        check("rst_sadr", {s_adr, s_dat_out}, 128'd0);
        rst_i = 1'b0;
        tick();
        check("rst_state", 128'(dbg_state), 128'd0);

        // read lane 1 on ch1, unselected ch3 acks first
        start(1'b0, 16'h00F0, 32'hFFDC1108,
              {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        exp_q.push_back({4{32'h12345678}});
        s_ack = 4'b1000;
        s_dat_in[127:96] = 32'h99999999;
        tick();
        check("rd_req_state", 128'(dbg_state), 128'd1);
        check("rd_req_strobes", {s_cyc, s_stb, s_we, m_ack}, 128'b1100);
        check("rd_cs_lowest", 128'(s_cs), 128'b0010);
        check("rd_adr", 128'(s_adr), 128'hFFDC1104);
        check("rd_sel", 128'(s_sel), 128'hF);
        tick();
        check("rd_unsel_ack_ignored", {dbg_state, m_ack}, {2'd1, 1'b0});
        s_ack = 4'b0010;
        s_dat_in[63:32] = 32'h12345678;
        tick();
        check("rd_ack_err", {m_ack, m_err, s_cyc, s_cs}, 128'b1000000);
        check("rd_data", m_dat_out, exp_q.pop_front());
        s_ack = 4'd0;
        tick();
        check("rd_hold", {dbg_state, m_ack}, {2'd3, 1'b0});
        check("rd_data_kept", m_dat_out, {4{32'h12345678}});
        tick();
        tick();
        check("hold_no_new_txn", {dbg_state, s_cyc}, {2'd3, 1'b0});
        m_stb = 1'b0;
        m_cyc = 1'b0;
        tick();
        check("hold_release", 128'(dbg_state), 128'd0);

        // write lane 3 on ch0
        start(1'b1, 16'hF000, 32'h12345600, {32'hCAFEBABE, 32'h0, 32'h0, 32'h0});
        tick();
        check("wr_dat", 128'(s_dat_out), 128'hCAFEBABE);
        check("wr_sel_we_cs", {s_sel, s_we, s_cs}, {4'hF, 1'b1, 4'b0001});
        check("wr_adr", 128'(s_adr), 128'h1234560C);
        s_ack = 4'b0001;
        s_dat_in[31:0] = 32'hDEADBEEF;
        tick();
        check("wr_ack", {m_ack, m_err}, 128'b10);
        check("wr_mdat_unchanged", m_dat_out, {4{32'h12345678}});
        finish_txn();

        // read lane 0 on ch2
        start(1'b0, 16'h0003, 32'hABCD00F0, {96'd0, 32'h55AA55AA});
        exp_q.push_back({4{32'hA5A50001}});
        tick();
        check("l0_cs_sel", {s_cs, s_sel}, {4'b0100, 4'h3});
        check("l0_adr_dat", {s_adr, s_dat_out}, {32'hABCD00F0, 32'h55AA55AA});
        s_ack = 4'b0100;
        s_dat_in[95:64] = 32'hA5A50001;
        tick();
        check("l0_ack", 128'(m_ack), 128'd1);
        check("l0_data", m_dat_out, exp_q.pop_front());
        finish_txn();

        // two nonzero nybbles
        start(1'b0, 16'h00FF, 32'hFFDC1108, 128'd0);
        tick();
        check("bad_sel_err", {m_err, m_ack, s_cyc, dbg_state}, {1'b1, 1'b0, 1'b0, 2'd2});
        check("bad_sel_mdat", m_dat_out, {4{32'hA5A50001}});
        tick();
        check("bad_sel_err_pulse", {m_err, dbg_state}, {1'b0, 2'd3});
        finish_txn();

        // address matching no base
        start(1'b1, 16'h000F, 32'h00000100, 128'd0);
        tick();
        check("nomatch_err", {m_err, m_ack, s_cyc}, 128'b100);
        finish_txn();

        // all-zero selects
        start(1'b0, 16'h0000, 32'hFFDC1100, 128'd0);
        tick();
        check("zero_sel_err", {m_err, m_ack, s_cyc}, 128'b100);
        finish_txn();

        // master abort during REQ
        start(1'b0, 16'h000F, 32'hFFDC1100, 128'd0);
        tick();
        check("abort_req", 128'(s_cyc), 128'd1);
        m_cyc = 1'b0;
        m_stb = 1'b0;
        tick();
        check("abort_drop", {s_cyc, s_cs, m_ack, m_err, dbg_state}, 128'd0);
        tick();
        check("abort_no_resp", {m_ack, m_err}, 128'd0);

        // reset during REQ with an ack in the reset cycle
        start(1'b0, 16'h000F, 32'hFFDC1100, 128'd0);
        tick();
        check("rstmid_req", 128'(dbg_state), 128'd1);
        rst_i = 1'b1;
        s_ack = 4'b0010;
        s_dat_in[63:32] = 32'h77777777;
        tick();
        check("rstmid_outs", {m_ack, m_err, s_cyc, s_stb, s_cs, dbg_state}, 128'd0);
        check("rstmid_mdat", m_dat_out, 128'd0);
        rst_i = 1'b0;
        s_ack = 4'd0;
        m_cyc = 1'b0;
        m_stb = 1'b0;
        tick();
        check("rstmid_no_ack", {m_ack, dbg_state}, 128'd0);

`ifdef ANY1_BRIDGE_TIMEOUT_EN
        // silent slave: eight REQ cycles, then error
        start(1'b0, 16'h000F, 32'hFFDC1100, 128'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_waiting", {dbg_state, m_err}, {2'd1, 1'b0});
        end
        tick();
        check("tmo_err", {m_err, m_ack, s_cyc}, 128'b100);
        finish_txn();

        // ack arriving in the limit cycle completes normally
        start(1'b0, 16'h000F, 32'hFFDC1100, 128'd0);
        tick();
        repeat (7) tick();
        s_ack = 4'b0010;
        s_dat_in[63:32] = 32'h0BADF00D;
        exp_q.push_back({4{32'h0BADF00D}});
        tick();
        check("tmo_ack_wins", {m_ack, m_err}, 128'b10);
        check("tmo_ack_data", m_dat_out, exp_q.pop_front());
        finish_txn();
`else
        // no timeout: REQ persists with a silent slave
        start(1'b0, 16'h000F, 32'hFFDC1100, 128'd0);
        tick();
        repeat (1000) tick();
        check("notmo_still_req", {dbg_state, s_cyc, m_err}, {2'd1, 1'b1, 1'b0});
        m_cyc = 1'b0;
        m_stb = 1'b0;
        tick();
        check("notmo_abort", {dbg_state, s_cyc}, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
